sprite_pixel_mapper: RTL
========================

// Module: sprite_pixel_mapper
// PURPOSE
//   Pipelined successor to the game's pixel color mapper. Per VGA pixel, resolves
//   N_BULLETS bullet channels, the player rectangle and the enemy sprite into registered RGB.
//   Latches bullet/enemy collisions per frame for game logic. Sits between the sprite
//   position logic and the VGA controller; the display path delays sync signals by LAT=2.
// PARAMETERS
//   N_BULLETS   4         number of independent bullet channels (1..8)
//   BULLET_LEN  4         bullet height in pixels (vertical line, 1 px wide)
//   PLAYER_W    16        player rectangle width, px
//   PLAYER_H    8         player rectangle height, px
//   PLAYER_Y    440       player rectangle top row
//   H_LAST      639       last visible DrawX
//   V_LAST      479       last visible DrawY
//   BG_COLOR    24'h0     background RGB
//   BLINK_SHIFT 4         blink half-period = 2^BLINK_SHIFT frames (SPRITE_BLINK_EN only)
// PORTS
//   Clk            in   1            pixel clock
//   Reset          in   1            synchronous, active-high
//   DrawX, DrawY   in   10 each      current pixel coordinate
//   bullet_in      in   N_BULLETS    per-channel bullet active
//   bulletX        in   10*N         packed, channel i = [10*i+:10]
//   bulletY        in   10*N         packed, top row of bullet i
//   bullet_color   in   24*N         packed RGB per channel
//   playerX        in   10           player rectangle left column
//   player_color   in   24           player RGB
//   player_blink   in   1            request blinking (used only with SPRITE_BLINK_EN)
//   enemy_pixel    in   1            enemy sprite opaque at (DrawX,DrawY), same cycle
//   enemy_color    in   24           enemy RGB, same cycle
//   Red,Green,Blue out  8 each       registered pixel color, LAT=2
//   hit_flags      out  N_BULLETS    bullet i touched an enemy pixel last frame
//   hit_valid      out  1            1-cycle pulse when hit_flags is updated
// BEHAVIOUR
//   - Reset: Red/Green/Blue=0, hit_flags=0, hit_valid=0, both pipe stages and
//     accumulators cleared; frame counter=0. Mid-frame reset discards partial hits.
//   - Stage 1 (registered): bullet_on[i] = bullet_in[i] && DrawX==bulletX[i] &&
//     (DrawY-bulletY[i]) computed 10-bit unsigned < BULLET_LEN. DrawY<bulletY wraps
//     large and is never on. player_on = DrawX in [playerX, playerX+PLAYER_W-1] and
//     DrawY in [PLAYER_Y, PLAYER_Y+PLAYER_H-1]; bounds computed in 11 bits, no wrap.
//     Register enemy_pixel, enemy_color and the frame-end flag alongside.
//   - Stage 2 (registered): priority = lowest-index active bullet, then player,
//     then enemy, then BG_COLOR. Any pixel with DrawX>H_LAST or DrawY>V_LAST -> 0.
//   - Latency: exactly 2 Clk from DrawX/DrawY to RGB. No stalls.
//   - Collisions: acc[i] |= bullet_on[i] && enemy_pixel at stage 1 output.
//     Frame end = (DrawX==H_LAST && DrawY==V_LAST), seen at stage 1. On that cycle
//     hit_flags <= acc | this pixel's hits, acc <= 0, and hit_valid=1 for 1 cycle.
//     So a hit on the last pixel is published, not lost. Flags hold until the next frame end.
//   - Multiple bullets on one pixel: each sets its own flag; color from lowest index.
//   - Frame counter (10-bit, wraps) increments at each frame end.
// CONFIGURATION
//   SPRITE_BLINK_EN defined: if player_blink=1, player_on is forced to 0 while
//     frame_cnt[BLINK_SHIFT]=1. Pixels fall through to enemy/BG. Collisions unaffected.
//   SPRITE_BLINK_EN undefined: player_blink ignored, no frame-counter gating; player
//     always drawn. Counter may be optimised away.
// TESTING
//   1. Reset held 3 cycles mid-scan -> RGB=0, hit_flags=0, hit_valid=0; first
//      pixel after release appears exactly 2 cycles later.
//   2. bullet0 at (100,200), BULLET_LEN=4, color FF0000 -> red at DrawY 200..203,
//      X=100 only. DrawY=199 and 204 show BG. bulletY=5, DrawY=2 -> BG (no wrap hit).
//   3. bullet1 and player overlap at (playerX,PLAYER_Y) -> bullet1 color. Add bullet0
//      on the same pixel -> bullet0 color.
//   4. enemy_pixel=1 under bullet2 mid-frame -> at frame end hit_flags=4'b0100,
//      hit_valid single pulse. Next frame without hits -> hit_flags=0.
//   5. Hit on pixel (H_LAST,V_LAST) -> included in that frame's hit_flags.
//   6. SPRITE_BLINK_EN, BLINK_SHIFT=1, player_blink=1 -> player visible frames 0,1,
//      hidden 2,3, visible 4,5. Without macro -> visible every frame.

Source files
------------

// File: rtl/sprite_pixel_mapper.sv
// sprite_pixel_mapper: two-stage pixel colour resolver (bullets > player > enemy > BG)
// with per-frame bullet/enemy collision flags. Optional player blinking via SPRITE_BLINK_EN.
module sprite_pixel_mapper #(
  parameter int unsigned N_BULLETS   = 4,
  parameter int unsigned BULLET_LEN  = 4,
  parameter int unsigned PLAYER_W    = 16,
  parameter int unsigned PLAYER_H    = 8,
  parameter int unsigned PLAYER_Y    = 440,
  parameter int unsigned H_LAST      = 639,
  parameter int unsigned V_LAST      = 479,
  parameter logic [23:0] BG_COLOR    = 24'h0,
  parameter int unsigned BLINK_SHIFT = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic [N_BULLETS-1:0]    bullet_in,
  input  logic [10*N_BULLETS-1:0] bulletX,
  input  logic [10*N_BULLETS-1:0] bulletY,
  input  logic [24*N_BULLETS-1:0] bullet_color,
  input  logic [9:0]              playerX,
  input  logic [23:0]             player_color,
  input  logic                    player_blink,
  input  logic                    enemy_pixel,
  input  logic [23:0]             enemy_color,
  output logic [7:0]              Red,
  output logic [7:0]              Green,
  output logic [7:0]              Blue,
  output logic [N_BULLETS-1:0]    hit_flags,
  output logic                    hit_valid
);

  localparam int unsigned PW  = 10;
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned CW  = 24;
  localparam int unsigned FCW = 10;

  logic [N_BULLETS-1:0]    bullet_on_d, bullet_on_q;
  logic                    player_on_d, player_on_q;
  logic                    frame_end_d, frame_end_q;
  logic                    visible_d, visible_q;
  logic                    enemy_pix_q;
  logic [CW-1:0]           enemy_col_q, player_col_q;
  logic [CW*N_BULLETS-1:0] bullet_col_q;
  logic                    player_hide_c;
  logic [PW1-1:0]          px_hi_c;

  logic [CW-1:0]           color_d, rgb_q;
  logic [N_BULLETS-1:0]    hits_c;
  logic [N_BULLETS-1:0]    acc_d, acc_q;
  logic [N_BULLETS-1:0]    hit_flags_d, hit_flags_q;
  logic                    hit_valid_d, hit_valid_q;
  logic [FCW-1:0]          frame_cnt_d, frame_cnt_q;

`ifdef SPRITE_BLINK_EN
  assign player_hide_c = player_blink && frame_cnt_q[BLINK_SHIFT];
`else
  logic unused_blink_c;
  assign unused_blink_c = player_blink;
  assign player_hide_c  = 1'b0;
`endif

  // Stage 1 hit tests; bullet span uses wrapping 10-bit distance from its top row
  always_comb begin
    bullet_on_d = '0;
    for (int i = 0; i < int'(N_BULLETS); i++) begin
      bullet_on_d[i] = bullet_in[i] && (DrawX == bulletX[PW*i +: PW])
                       && (PW'(DrawY - bulletY[PW*i +: PW]) < PW'(BULLET_LEN));
    end
  end

  assign px_hi_c     = {1'b0, playerX} + PW1'(PLAYER_W - 1);
  assign player_on_d = (DrawX >= playerX) && ({1'b0, DrawX} <= px_hi_c)
                       && ({1'b0, DrawY} >= PW1'(PLAYER_Y))
                       && ({1'b0, DrawY} <= PW1'(PLAYER_Y + PLAYER_H - 1))
                       && !player_hide_c;
  assign frame_end_d = (DrawX == PW'(H_LAST)) && (DrawY == PW'(V_LAST));
  assign visible_d   = (DrawX <= PW'(H_LAST)) && (DrawY <= PW'(V_LAST));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bullet_on_q  <= '0;
      player_on_q  <= 1'b0;
      frame_end_q  <= 1'b0;
      visible_q    <= 1'b0;
      enemy_pix_q  <= 1'b0;
      enemy_col_q  <= '0;
      player_col_q <= '0;
      bullet_col_q <= '0;
    end else begin
      bullet_on_q  <= bullet_on_d;
      player_on_q  <= player_on_d;
      frame_end_q  <= frame_end_d;
      visible_q    <= visible_d;
      enemy_pix_q  <= enemy_pixel;
      enemy_col_q  <= enemy_color;
      player_col_q <= player_color;
      bullet_col_q <= bullet_color;
    end
  end

  // Stage 2 priority: lowest active bullet wins, so scan from the top index down
  always_comb begin
    color_d = BG_COLOR;
    if (enemy_pix_q) color_d = enemy_col_q;
    if (player_on_q) color_d = player_col_q;
    for (int i = int'(N_BULLETS) - 1; i >= 0; i--) begin
      if (bullet_on_q[i]) color_d = bullet_col_q[CW*i +: CW];
    end
    if (!visible_q) color_d = '0;
  end

  // Frame-end publishes the accumulator merged with the last pixel's own hits
  assign hits_c = bullet_on_q & {N_BULLETS{enemy_pix_q}};

  always_comb begin
    acc_d       = acc_q | hits_c;
    hit_flags_d = hit_flags_q;
    hit_valid_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (frame_end_q) begin
      hit_flags_d = acc_q | hits_c;
      acc_d       = '0;
      hit_valid_d = 1'b1;
      frame_cnt_d = frame_cnt_q + FCW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q       <= '0;
      acc_q       <= '0;
      hit_flags_q <= '0;
      hit_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      rgb_q       <= color_d;
      acc_q       <= acc_d;
      hit_flags_q <= hit_flags_d;
      hit_valid_q <= hit_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign Red       = rgb_q[23:16];
  assign Green     = rgb_q[15:8];
  assign Blue      = rgb_q[7:0];
  assign hit_flags = hit_flags_q;
  assign hit_valid = hit_valid_q;

endmodule
